// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// microcode_sequencer : fetches uops, issues control words, computes next uaddr
// Revision 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
   parameter int UOP_BUF_SIZE  = 128,
   parameter int UOP_BUF_WIDTH = 64,
   parameter int STACK_DEPTH   = 4,
   parameter int NUM_COND      = 8,
   parameter int RESET_ADDR    = 0,
   localparam int ADDR_W       = $clog2(UOP_BUF_SIZE),
   localparam int CTRL_W       = UOP_BUF_WIDTH - 8 - ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [ADDR_W-1:0]        uop_addr,
   input  logic [UOP_BUF_WIDTH-1:0] uop,
   input  logic [NUM_COND-1:0]      cond,
   input  logic                     dispatch_valid,
   input  logic [ADDR_W-1:0]        dispatch_addr,
   output logic                     dispatch_ready,
   output logic                     ctrl_valid,
   input  logic                     ctrl_ready,
   output logic [CTRL_W-1:0]        ctrl_word,
   output logic                     halted,
   output logic                     error
);

   localparam int SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_NEXT     = 3'd0;
   localparam logic [2:0] OP_JUMP     = 3'd1;
   localparam logic [2:0] OP_BRANCH   = 3'd2;
   localparam logic [2:0] OP_CALL     = 3'd3;
   localparam logic [2:0] OP_RET      = 3'd4;
   localparam logic [2:0] OP_DISPATCH = 3'd5;
   localparam logic [2:0] OP_HALT     = 3'd6;

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

   state_t              r_state, w_next_state;
   logic [ADDR_W-1:0]   r_addr, w_next_addr, w_pc_inc, w_target;
   logic [SP_W-1:0]     r_sp, w_next_sp;
   logic                r_error, w_next_error;
   logic                w_push, w_taken, w_transfer;
   logic [2:0]          w_op;
   logic [3:0]          w_csel;
   logic                w_inv;
   logic [15:0]         w_cond_pad;
   logic [STK_IW-1:0]   w_pop_idx;
   logic [ADDR_W-1:0]   r_stack [2**STK_IW];

   assign w_op     = uop[2:0];
   assign w_csel   = uop[6:3];
   assign w_inv    = uop[7];
   assign w_target = uop[8+ADDR_W-1:8];
   assign w_pc_inc = r_addr + 1'b1;
   assign w_pop_idx = STK_IW'(r_sp - 1'b1);

   // Condition selects beyond NUM_COND read as zero.
   always_comb begin
      w_cond_pad = '0;
      w_cond_pad[NUM_COND-1:0] = cond;
   end
   assign w_taken = w_cond_pad[w_csel] ^ w_inv;

   assign ctrl_valid     = (r_state == ST_RUN) && !(w_op == OP_DISPATCH && !dispatch_valid);
   assign dispatch_ready = (r_state == ST_RUN) && (w_op == OP_DISPATCH) && dispatch_valid && ctrl_ready;
   assign w_transfer     = ctrl_valid && ctrl_ready;
   assign ctrl_word      = uop[UOP_BUF_WIDTH-1:8+ADDR_W];
   assign uop_addr       = r_addr;
   assign halted         = (r_state == ST_HALTED);
   assign error          = r_error;

   always_comb begin
      w_next_addr  = r_addr;
      w_next_sp    = r_sp;
      w_next_state = r_state;
      w_next_error = r_error;
      w_push       = 1'b0;
      if (w_transfer) begin
         case (w_op)
            OP_NEXT:   w_next_addr = w_pc_inc;
            OP_JUMP:   w_next_addr = w_target;
            OP_BRANCH: w_next_addr = w_taken ? w_target : w_pc_inc;
            OP_CALL: begin
               if (r_sp == SP_W'(STACK_DEPTH)) begin
                  w_next_error = 1'b1;
                  w_next_state = ST_HALTED;
               end else begin
                  w_push      = 1'b1;
                  w_next_sp   = r_sp + 1'b1;
                  w_next_addr = w_target;
               end
            end
            OP_RET: begin
               if (r_sp == '0) begin
                  w_next_error = 1'b1;
                  w_next_state = ST_HALTED;
               end else begin
                  w_next_sp   = r_sp - 1'b1;
                  w_next_addr = r_stack[w_pop_idx];
               end
            end
            OP_DISPATCH: w_next_addr = dispatch_addr;
            OP_HALT:     w_next_state = ST_HALTED;
            default: begin
               w_next_error = 1'b1;
               w_next_state = ST_HALTED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RUN;
         r_addr  <= ADDR_W'(RESET_ADDR);
         r_sp    <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_addr  <= w_next_addr;
         r_sp    <= w_next_sp;
         r_error <= w_next_error;
      end
   end

   // Stack contents need no reset: sp alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[r_sp[STK_IW-1:0]] <= w_pc_inc;
   end

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_microcode_sequencer : directed scoreboard bench for microcode_sequencer
// Revision 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

   logic        clk;
   logic        reset, rst_w, rst_s;
   logic [7:0]  cond;
   logic        dv;
   logic [6:0]  da;
   logic        ready;
   logic [63:0] mem [128];

   logic [6:0]  addr_m, addr_w, addr_s;
   logic        dr_m, dr_w, dr_s, cv_m, cv_w, cv_s, h_m, h_w, h_s, e_m, e_w, e_s;
   logic [48:0] cw_m, cw_w, cw_s;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { string tag; logic [63:0] v; } exp_t;
   exp_t sb [$];

   microcode_sequencer dut_m (
      .clk(clk), .reset(reset), .uop_addr(addr_m), .uop(mem[addr_m]), .cond(cond),
      .dispatch_valid(dv), .dispatch_addr(da), .dispatch_ready(dr_m), .ctrl_valid(cv_m),
      .ctrl_ready(ready), .ctrl_word(cw_m), .halted(h_m), .error(e_m));

   microcode_sequencer #(.RESET_ADDR(126)) dut_w (
      .clk(clk), .reset(rst_w), .uop_addr(addr_w), .uop(mem[addr_w]), .cond(cond),
      .dispatch_valid(dv), .dispatch_addr(da), .dispatch_ready(dr_w), .ctrl_valid(cv_w),
      .ctrl_ready(ready), .ctrl_word(cw_w), .halted(h_w), .error(e_w));

   microcode_sequencer #(.STACK_DEPTH(1)) dut_s (
      .clk(clk), .reset(rst_s), .uop_addr(addr_s), .uop(mem[addr_s]), .cond(cond),
      .dispatch_valid(dv), .dispatch_addr(da), .dispatch_ready(dr_s), .ctrl_valid(cv_s),
      .ctrl_ready(ready), .ctrl_word(cw_s), .halted(h_s), .error(e_s));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] mk(logic [2:0] op, logic [3:0] csel, logic inv,
                                      logic [6:0] tgt, logic [48:0] ctrl);
      return {ctrl, tgt, inv, csel, op};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(string tag, logic [63:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_chk(logic [63:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.v);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   // Hold main DUT in reset for one cycle, then release at a falling edge.
   task automatic restart();
      reset = 1'b0;
      next_cyc();
      reset = 1'b1;
   endtask

   task automatic branch_case(string tag, logic inv, logic [3:0] csel, logic [7:0] c, logic [6:0] exp);
      reset = 1'b0;
      mem[0] = mk(3'd2, csel, inv, 7'd40, 49'h1234);
      cond = c;
      next_cyc();
      reset = 1'b1;
      push_exp(tag, 64'(exp));
      next_cyc();
      pop_chk(64'(addr_m));
   endtask

   initial begin
      logic [6:0] wrap_seq [3];
      logic [6:0] cr_seq [4];
      wrap_seq = '{7'd127, 7'd0, 7'd1};
      cr_seq   = '{7'd10, 7'd20, 7'd11, 7'd1};
      reset = 1'b0; rst_w = 1'b0; rst_s = 1'b0;
      cond = '0; dv = 1'b0; da = '0; ready = 1'b1;
      for (int i = 0; i < 128; i++) mem[i] = mk(3'd0, 4'd0, 1'b0, 7'd0, 49'(i + 'h100));
      #12;
      chk("reset_addr", 64'(addr_m), 64'd0);
      chk("reset_halted", 64'(h_m), 64'd0);
      chk("reset_error", 64'(e_m), 64'd0);

      // Sequential run and wrap on the RESET_ADDR=126 instance
      next_cyc();
      rst_w = 1'b1;
      chk("wrap_start", 64'(addr_w), 64'd126);
      chk("wrap_ctrl_word", 64'(cw_w), 64'h100 + 64'd126);
      for (int k = 0; k < 3; k++) begin
         chk("wrap_valid", 64'(cv_w), 64'd1);
         push_exp("wrap_addr", 64'(wrap_seq[k]));
         next_cyc();
         pop_chk(64'(addr_w));
      end
      rst_w = 1'b0;

      // Branch taken / not taken / inverted / out-of-range select
      branch_case("br_taken", 1'b0, 4'd2, 8'h04, 7'd40);
      branch_case("br_not_taken", 1'b0, 4'd2, 8'h00, 7'd1);
      branch_case("br_inv", 1'b1, 4'd2, 8'h04, 7'd1);
      branch_case("br_csel_oob", 1'b1, 4'd9, 8'hFF, 7'd40);
      branch_case("br_csel_top", 1'b0, 4'd7, 8'h80, 7'd40);

      // Backpressure: stall three cycles on the branch at 0
      reset = 1'b0;
      mem[0] = mk(3'd2, 4'd2, 1'b0, 7'd40, 49'h1234);
      cond = 8'h04;
      ready = 1'b0;
      next_cyc();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         chk("stall_addr", 64'(addr_m), 64'd0);
         chk("stall_word", 64'(cw_m), 64'h1234);
      end
      chk("stall_valid", 64'(cv_m), 64'd1);
      ready = 1'b1;
      push_exp("stall_release", 64'd40);
      next_cyc();
      pop_chk(64'(addr_m));

      // Call/return nesting, then RET with empty stack underflows
      reset = 1'b0;
      mem[0]  = mk(3'd3, 4'd0, 1'b0, 7'd10, 49'h0A0);
      mem[10] = mk(3'd3, 4'd0, 1'b0, 7'd20, 49'h0AA);
      mem[20] = mk(3'd4, 4'd0, 1'b0, 7'd0,  49'h0B0);
      mem[11] = mk(3'd4, 4'd0, 1'b0, 7'd0,  49'h0B1);
      mem[1]  = mk(3'd4, 4'd0, 1'b0, 7'd0,  49'h0B2);
      next_cyc();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_exp("callret_addr", 64'(cr_seq[k]));
         next_cyc();
         pop_chk(64'(addr_m));
      end
      chk("underflow_valid", 64'(cv_m), 64'd1);
      chk("underflow_err_before", 64'(e_m), 64'd0);
      next_cyc();
      chk("underflow_error", 64'(e_m), 64'd1);
      chk("underflow_halted", 64'(h_m), 64'd1);
      chk("halted_valid", 64'(cv_m), 64'd0);

      // Stack overflow on the STACK_DEPTH=1 instance
      reset = 1'b0;
      rst_s = 1'b1;
      next_cyc();
      chk("ovf_first_call", 64'(addr_s), 64'd10);
      chk("ovf_err_before", 64'(e_s), 64'd0);
      next_cyc();
      chk("ovf_error", 64'(e_s), 64'd1);
      chk("ovf_halted", 64'(h_s), 64'd1);
      rst_s = 1'b0;

      // Dispatch handshake
      mem[0] = mk(3'd1, 4'd0, 1'b0, 7'd5, 49'h0C0);
      mem[5] = mk(3'd5, 4'd0, 1'b0, 7'd0, 49'h0C5);
      dv = 1'b0;
      next_cyc();
      reset = 1'b1;
      push_exp("disp_jump", 64'd5);
      next_cyc();
      pop_chk(64'(addr_m));
      for (int k = 0; k < 2; k++) begin
         chk("disp_wait_valid", 64'(cv_m), 64'd0);
         chk("disp_wait_ready", 64'(dr_m), 64'd0);
         next_cyc();
         chk("disp_wait_addr", 64'(addr_m), 64'd5);
      end
      dv = 1'b1; da = 7'd77; ready = 1'b0;
      #1;
      chk("disp_stalled_ready", 64'(dr_m), 64'd0);
      chk("disp_valid", 64'(cv_m), 64'd1);
      ready = 1'b1;
      #1;
      chk("disp_ready", 64'(dr_m), 64'd1);
      push_exp("disp_target", 64'd77);
      next_cyc();
      pop_chk(64'(addr_m));
      dv = 1'b0;

      // Reserved op faults
      reset = 1'b0;
      mem[0] = mk(3'd7, 4'd0, 1'b0, 7'd0, 49'h0D0);
      next_cyc();
      reset = 1'b1;
      chk("rsvd_valid", 64'(cv_m), 64'd1);
      next_cyc();
      chk("rsvd_error", 64'(e_m), 64'd1);
      chk("rsvd_halted", 64'(h_m), 64'd1);

      // HALT: stops cleanly without error
      reset = 1'b0;
      mem[0] = mk(3'd6, 4'd0, 1'b0, 7'd0, 49'h0E0);
      next_cyc();
      reset = 1'b1;
      next_cyc();
      chk("halt_halted", 64'(h_m), 64'd1);
      chk("halt_error", 64'(e_m), 64'd0);
      chk("halt_addr", 64'(addr_m), 64'd0);
      for (int k = 0; k < 10; k++) begin
         chk("halt_no_valid", 64'(cv_m), 64'd0);
         next_cyc();
      end

      // Asynchronous reset mid-run after a fault with two frames on the stack
      reset = 1'b0;
      mem[0]  = mk(3'd3, 4'd0, 1'b0, 7'd10, 49'h0A0);
      mem[10] = mk(3'd3, 4'd0, 1'b0, 7'd20, 49'h0AA);
      mem[20] = mk(3'd7, 4'd0, 1'b0, 7'd0,  49'h0F0);
      next_cyc();
      restart();
      reset = 1'b1;
      next_cyc();
      next_cyc();
      chk("arst_deep_addr", 64'(addr_m), 64'd20);
      next_cyc();
      chk("arst_pre_error", 64'(e_m), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_addr", 64'(addr_m), 64'd0);
      chk("arst_halted", 64'(h_m), 64'd0);
      chk("arst_error", 64'(e_m), 64'd0);
      mem[0] = mk(3'd4, 4'd0, 1'b0, 7'd0, 49'h0F1);
      next_cyc();
      reset = 1'b1;
      chk("arst_ret_valid", 64'(cv_m), 64'd1);
      next_cyc();
      chk("arst_sp_zero", 64'(e_m), 64'd1);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised next-generation microcode unit.
- Fetches micro-ops from an external combinational uop store and issues their control words to the backend with a valid/ready handshake.
- Computes the next micro-address in hardware: sequential, jump, conditional branch, call/return through a bounded stack, and dispatch to an externally supplied entry point.
- Sits between the decode front-end, which provides dispatch entries, and the execution backend, which consumes control words.

Parameters:
- UOP_BUF_SIZE, 128, number of uop store entries; must be a power of two.
- UOP_BUF_WIDTH, 64, bits per uop; must be greater than 8+ADDR_W.
- STACK_DEPTH, 4, call/return stack entries (>=1).
- NUM_COND, 8, number of condition inputs (1..16).
- RESET_ADDR, 0, micro-address fetched after reset.
- Derived: ADDR_W = $clog2(UOP_BUF_SIZE); CTRL_W = UOP_BUF_WIDTH-8-ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- uop_addr  out  ADDR_W  current micro-address (registered)
- uop  in  UOP_BUF_WIDTH  store contents at uop_addr, valid in the same cycle
- cond  in  NUM_COND  branch condition flags
- dispatch_valid  in  1  dispatch entry available
- dispatch_addr  in  ADDR_W  dispatch target
- dispatch_ready  out  1  dispatch entry consumed this cycle
- ctrl_valid  out  1  ctrl_word valid
- ctrl_ready  in  1  backend accepts ctrl_word
- ctrl_word  out  CTRL_W  uop[UOP_BUF_WIDTH-1:8+ADDR_W]
- halted  out  1  sequencer stopped
- error  out  1  sticky fault (stack overflow/underflow, reserved op)

Behaviour:
- Uop fields:
  - op = uop[2:0]
  - csel = uop[6:3]
  - inv = uop[7]
  - target = uop[8+ADDR_W-1:8]
- States: RUN, HALTED.
- Reset (asynchronous, reset=0):
  - uop_addr=RESET_ADDR, sp=0, state=RUN.
  - halted=0, error=0.
  - Outputs settle combinationally from these values.
- Output logic:
  - ctrl_valid = RUN && !(op==DISPATCH && !dispatch_valid).
  - dispatch_ready = RUN && op==DISPATCH && dispatch_valid && ctrl_ready.
  - ctrl_word is driven unconditionally.
- Transfer = ctrl_valid && ctrl_ready. On transfer, uop_addr updates at the next clk edge per op:
  - 0 NEXT: pc+1.
  - 1 JUMP: target.
  - 2 BRANCH: take target if (cond[csel]^inv), else pc+1; csel>=NUM_COND reads cond as 0.
  - 3 CALL: push pc+1, go to target. If sp==STACK_DEPTH, no push, error=1, state=HALTED.
  - 4 RET: pop into uop_addr. If sp==0, error=1, state=HALTED.
  - 5 DISPATCH: go to dispatch_addr; the entry is consumed.
  - 6 HALT: state=HALTED, uop_addr unchanged.
  - 7 reserved: error=1, state=HALTED.
- Faulting uops (overflow, underflow, reserved) still transfer their ctrl_word.
- pc+1 wraps from UOP_BUF_SIZE-1 to 0.
- No transfer: uop_addr, sp and state hold. A stalled backend (ctrl_ready=0) freezes the sequencer with ctrl_word stable.
- HALTED:
  - ctrl_valid=0, dispatch_ready=0, halted=1.
  - Left only via reset.
- error is sticky until reset.
- Latency: one uop per cycle at full throughput; branch/call/ret/dispatch add no bubble.
- Reset asserted mid-operation: stack contents are discarded and sp=0. Any pending dispatch is not acknowledged.

Test Plan:
- Sequential run and wrap: store[i]=NEXT for all i, RESET_ADDR=126, ctrl_ready=1 → uop_addr sequence 126,127,0,1; ctrl_valid=1 every cycle.
- Branch and backpressure:
  - store[0]=BRANCH csel=2 inv=0 target=40. cond[2]=1 → next addr 40; cond[2]=0 → 1; inv=1 with cond[2]=1 → 1.
  - Holding ctrl_ready=0 for 3 cycles keeps uop_addr=0 and ctrl_word constant.
- Call/return nesting:
  - store[0]=CALL→10, store[10]=CALL→20, store[20]=RET, store[11]=RET → addresses 0,10,20,11,1; sp returns to 0.
  - With STACK_DEPTH=1, the second CALL sets error=1 and halted=1 next cycle.
- Dispatch handshake: store[5]=DISPATCH, dispatch_valid=0 for 2 cycles → ctrl_valid=0 and uop_addr=5 held; then dispatch_valid=1, dispatch_addr=77 → dispatch_ready=1 that cycle, uop_addr=77 next.
- Underflow, reserved op and halt:
  - RET with sp=0 → error=1, halted=1.
  - op=7 → same.
  - op=6 → halted=1, error=0; ctrl_valid stays 0 for 10 cycles.
- Asynchronous reset mid-run: assert reset=0 between clk edges during a CALL chain → uop_addr=RESET_ADDR, halted=0, error=0 immediately. After release, a RET faults, proving sp=0.
